seq_mult_param: RTL and testbench



---
 rtl/mult_pkg.sv | 13 +
 rtl/seq_mult_param_if.sv | 34 +++
 rtl/seq_mult_ctrl.sv | 70 +++++++
 rtl/seq_mult_param.sv | 82 ++++++++
 tb/tb_seq_mult_param.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and limits for the parametrised sequential multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/seq_mult_param_if.sv
// Operand/result bus between operand masters and the sequential multiplier.
interface seq_mult_param_if #(
    parameter int WIDTH = 8
);

    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       ABus;
    logic [WIDTH-1:0]       BBus;
    logic                   ready;
    logic                   done;
    logic [2*WIDTH-1:0]     resultBus;

    modport master (
        output start,
        output signed_mode,
        output ABus,
        output BBus,
        input  ready,
        input  done,
        input  resultBus
    );

    modport slave (
        input  start,
        input  signed_mode,
        input  ABus,
        input  BBus,
        output ready,
        output done,
        output resultBus
    );

endinterface

// File: rtl/seq_mult_ctrl.sv
// Sequencer for the shift-add multiplier: state, step counter, handshake flags.
module seq_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic ready,
    output logic done,
    output logic capture,
    output logic step,
    output logic last_step
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt holds at WIDTH-1 after the final step rather than wrapping.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready     = 1'b0;
        done      = 1'b0;
        capture   = 1'b0;
        step      = 1'b0;
        last_step = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    last_step = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/seq_mult_param.sv
// WIDTH-bit sequential shift-add multiplier, unsigned or two's-complement,
// one add-shift step per clock; product presented as {Preg, Areg}.
module seq_mult_param
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    seq_mult_param_if.slave  bus
);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("seq_mult_param: WIDTH %0d outside %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
    end

    logic capture;
    logic step;
    logic last_step;

    seq_mult_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .start     (bus.start),
        .ready     (bus.ready),
        .done      (bus.done),
        .capture   (capture),
        .step      (step),
        .last_step (last_step)
    );

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic             mode_q, mode_d;

    logic [WIDTH:0]   p_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            mode_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            p_q    <= p_d;
            mode_q <= mode_d;
        end
    end

    // Signed mode subtracts on the final step because the multiplier MSB carries negative weight.
    always_comb begin
        p_ext  = {mode_q & p_q[WIDTH-1], p_q};
        b_ext  = {mode_q & b_q[WIDTH-1], b_q};
        addend = a_q[0] ? b_ext : '0;
        sum    = (mode_q && last_step) ? (p_ext - addend) : (p_ext + addend);

        a_d    = a_q;
        b_d    = b_q;
        p_d    = p_q;
        mode_d = mode_q;
        if (capture) begin
            a_d    = bus.ABus;
            b_d    = bus.BBus;
            p_d    = '0;
            mode_d = bus.signed_mode;
        end else if (step) begin
            p_d = sum[WIDTH:1];
            a_d = {sum[0], a_q[WIDTH-1:1]};
        end
    end

    assign bus.resultBus = {p_q, a_q};

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param: table of products on WIDTH=8 and
// WIDTH=4 instances, plus ignored-start, mid-calc reset and held-start runs.
module tb_seq_mult_param;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_mult_param_if #(.WIDTH(8)) bus8 ();
    seq_mult_param_if #(.WIDTH(4)) bus4 ();

    seq_mult_param #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    seq_mult_param #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    typedef struct {
        bit          w4;
        logic [7:0]  a;
        logic [7:0]  b;
        bit          sgn;
        logic [15:0] exp;
    } vec_t;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int done_cnt8  = 0;
    int done_cnt4  = 0;

    logic [15:0] q8[$];
    logic [7:0]  q4[$];

    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b,
                                               input bit sgn, input int w);
        longint sa, sb;
        logic [63:0] mask;
        mask = (64'd1 << (2 * w)) - 64'd1;
        sa = longint'(a & ((32'd1 << w) - 32'd1));
        sb = longint'(b & ((32'd1 << w) - 32'd1));
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        return 64'(sa * sb) & mask;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding product.
    always @(negedge clk) begin
        if (bus8.done === 1'b1) begin
            done_cnt8++;
            check_output("dut8 ready during done", 32'(bus8.ready), 32'd0);
            if (q8.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL dut8 unexpected done: result 0x%0h with empty scoreboard", bus8.resultBus);
            end else begin
                check_output("dut8 product", 32'(bus8.resultBus), 32'(q8.pop_front()));
            end
        end
        if (bus4.done === 1'b1) begin
            done_cnt4++;
            check_output("dut4 ready during done", 32'(bus4.ready), 32'd0);
            if (q4.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL dut4 unexpected done: result 0x%0h with empty scoreboard", bus4.resultBus);
            end else begin
                check_output("dut4 product", 32'(bus4.resultBus), 32'(q4.pop_front()));
            end
        end
    end

    task automatic wait_ready(input bit w4);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((w4 ? bus4.ready : bus8.ready) !== 1'b1) && n < 40);
        if ((w4 ? bus4.ready : bus8.ready) !== 1'b1) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL wait_ready timeout: ready=0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic wait_done(input bit w4, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (((w4 ? bus4.done : bus8.done) !== 1'b1) && lat < 40);
        if ((w4 ? bus4.done : bus8.done) !== 1'b1) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL wait_done timeout: done=0 after %0d cycles, required 1", lat);
        end
    endtask

    task automatic apply_stimulus(input bit w4, input logic [7:0] a, input logic [7:0] b,
                                  input bit sgn, input logic [15:0] exp);
        wait_ready(w4);
        if (w4) begin
            bus4.ABus        = a[3:0];
            bus4.BBus        = b[3:0];
            bus4.signed_mode = sgn;
            q4.push_back(exp[7:0]);
            bus4.start       = 1'b1;
        end else begin
            bus8.ABus        = a;
            bus8.BBus        = b;
            bus8.signed_mode = sgn;
            q8.push_back(exp);
            bus8.start       = 1'b1;
        end
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        bus8.start = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin : main
        int lat;
        int d0;
        int t_prev;
        logic [7:0] ha[4];
        logic [7:0] hb[4];
        bit         hs[4];

        vecs.push_back('{0, 8'hFF, 8'hFF, 0, 16'hFE01});
        vecs.push_back('{0, 8'hFD, 8'h05, 1, 16'hFFF1});
        vecs.push_back('{0, 8'h80, 8'h80, 1, 16'h4000});
        vecs.push_back('{0, 8'h7F, 8'hFF, 1, 16'hFF81});
        vecs.push_back('{0, 8'hC8, 8'h03, 0, 16'h0258});
        vecs.push_back('{0, 8'hFF, 8'hFF, 1, 16'h0001});
        vecs.push_back('{0, 8'h80, 8'h02, 0, 16'h0100});
        vecs.push_back('{0, 8'h80, 8'h02, 1, 16'hFF00});
        vecs.push_back('{0, 8'h00, 8'h00, 0, 16'h0000});
        vecs.push_back('{1, 8'h0F, 8'h0F, 0, 16'h00E1});
        vecs.push_back('{1, 8'h00, 8'h09, 0, 16'h0000});
        vecs.push_back('{1, 8'h08, 8'h08, 1, 16'h0040});
        vecs.push_back('{1, 8'h0F, 8'h07, 1, 16'h00F9});
        vecs.push_back('{1, 8'h07, 8'h07, 1, 16'h0031});

        rst = 1'b1;
        bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.ABus = '0; bus8.BBus = '0;
        bus4.start = 1'b0; bus4.signed_mode = 1'b0; bus4.ABus = '0; bus4.BBus = '0;
        repeat (2) @(negedge clk);
        check_output("reset dut8 ready", 32'(bus8.ready), 32'd1);
        check_output("reset dut8 done", 32'(bus8.done), 32'd0);
        check_output("reset dut8 result", 32'(bus8.resultBus), 32'd0);
        check_output("reset dut4 ready", 32'(bus4.ready), 32'd1);
        check_output("reset dut4 result", 32'(bus4.resultBus), 32'd0);
        rst = 1'b0;

        $display("[TB] table vectors");
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].w4, vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp);
            wait_done(vecs[i].w4, lat);
            check_output("start-to-done latency", 32'(lat), vecs[i].w4 ? 32'd5 : 32'd9);
            @(negedge clk);
            if (vecs[i].w4) begin
                check_output("dut4 ready after done", 32'(bus4.ready), 32'd1);
                check_output("dut4 result held", 32'(bus4.resultBus), 32'(vecs[i].exp[7:0]));
            end else begin
                check_output("dut8 ready after done", 32'(bus8.ready), 32'd1);
                check_output("dut8 done one cycle", 32'(bus8.done), 32'd0);
                check_output("dut8 result held", 32'(bus8.resultBus), 32'(vecs[i].exp));
            end
        end

        $display("[TB] start pulsed during calc");
        d0 = done_cnt8;
        apply_stimulus(0, 8'd10, 8'd20, 0, 16'(model_prod(32'd10, 32'd20, 0, 8)));
        repeat (3) @(negedge clk);
        bus8.ABus = 8'd99; bus8.BBus = 8'd99; bus8.signed_mode = 1'b1; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        wait_done(0, lat);
        repeat (15) @(negedge clk);
        check_output("ignored start done count", 32'(done_cnt8 - d0), 32'd1);
        check_output("ignored start queue empty", 32'(q8.size()), 32'd0);

        $display("[TB] reset during calc");
        apply_stimulus(0, 8'd77, 8'd3, 0, 16'(model_prod(32'd77, 32'd3, 0, 8)));
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_output("mid-calc reset ready", 32'(bus8.ready), 32'd1);
        check_output("mid-calc reset done", 32'(bus8.done), 32'd0);
        check_output("mid-calc reset result", 32'(bus8.resultBus), 32'd0);
        q8.delete();
        d0 = done_cnt8;
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check_output("no done after abort", 32'(done_cnt8 - d0), 32'd0);
        apply_stimulus(0, 8'd2, 8'd3, 0, 16'h0006);
        wait_done(0, lat);
        check_output("post-reset latency", 32'(lat), 32'd9);
        check_output("post-reset result", 32'(bus8.resultBus), 32'h0006);

        $display("[TB] start held high");
        ha[0] = 8'h12; hb[0] = 8'h34; hs[0] = 1'b0;
        ha[1] = 8'hF0; hb[1] = 8'h0F; hs[1] = 1'b1;
        ha[2] = 8'h80; hb[2] = 8'h7F; hs[2] = 1'b1;
        ha[3] = 8'hAB; hb[3] = 8'hCD; hs[3] = 1'b0;
        t_prev = 0;
        bus8.start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ready(0);
            bus8.ABus = ha[k];
            bus8.BBus = hb[k];
            bus8.signed_mode = hs[k];
            q8.push_back(16'(model_prod(32'(ha[k]), 32'(hb[k]), hs[k], 8)));
            wait_done(0, lat);
            check_output("held-start latency", 32'(lat), 32'd9);
            if (k > 0) check_output("held-start done period", 32'(cyc - t_prev), 32'd10);
            t_prev = cyc;
        end
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);

        check_output("dut8 scoreboard drained", 32'(q8.size()), 32'd0);
        check_output("dut4 scoreboard drained", 32'(q4.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
